fpu_issue_ctrl: RTL

Sequencing front-end for the single-cycle bfloat16 FPU top (one registered result cycle).
- Accepts operation requests from a scalar requester and a vector requester, arbitrating round-robin between them.
- Converts each 5-bit opcode index into the one-hot sfpu_op/vfpu_op bus and drives operands for exactly one cycle.
- Captures the FPU's registered outputs and returns them on a valid/ready response port.
- Accumulates the sticky fflags CSR.

---
 rtl/fpu_ctrl_pkg.sv | 45 ++++
 rtl/fpu_rr_arb2.sv | 35 +++
 rtl/fpu_issue_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/fpu_ctrl_pkg.sv
// Shared types and constants for the bfloat16 FPU issue controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

  localparam int S_OP_W = 24;
  localparam int V_OP_W = 28;

  // Opcode indices (bit positions in the one-hot op buses)
  localparam logic [4:0] OP_FADD   = 5'd0;
  localparam logic [4:0] OP_FSUB   = 5'd1;
  localparam logic [4:0] OP_FMUL   = 5'd2;
  localparam logic [4:0] OP_FCLASS = 5'd21;
  localparam logic [4:0] V_OP_FMUL = 5'd12;

  localparam logic [4:0] S_OP_MAX = 5'd21;
  localparam logic [4:0] V_OP_MAX = 5'd27;

  // Vector indices 11, 15, 16, 17 have no FPU operation behind them
  localparam logic [V_OP_W-1:0] V_RSVD_MASK = 28'h003_8800;

  // Flag bit positions within {NV,DZ,OF,UF,NX}
  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;
  localparam logic [4:0] FLAGS_ILLEGAL = 5'b1_0000;

  // True when the opcode index maps onto a real FPU operation for that source
  function automatic logic op_is_legal(input logic is_vec, input logic [4:0] op);
    logic [31:0] rsvd;
    rsvd = {4'b0, V_RSVD_MASK};
    if (is_vec) return (op <= V_OP_MAX) && !rsvd[op];
    return op <= S_OP_MAX;
  endfunction

endpackage

// File: rtl/fpu_rr_arb2.sv
// Two-way round-robin arbiter between the scalar and vector requesters.
// Latency: combinational grant; priority state updates on the advance edge.
// Backpressure: grant only names a winner; caller qualifies it and pulses advance on accept.
module fpu_rr_arb2 (
  input  logic clk,
  input  logic rst_l,
  input  logic s_vld,
  input  logic v_vld,
  input  logic advance,
  output logic gnt_s,
  output logic gnt_v
);
  import fpu_ctrl_pkg::*;

  // 1 = vector was granted last; resets to 1 so scalar wins the first tie
  logic last_grant_q, last_grant_d;
  logic pick_v;

  // Winner: the only requester, or on a tie the one not granted last
  always_comb begin
    pick_v = v_vld;
    if (s_vld && v_vld) pick_v = !last_grant_q;
    gnt_s        = s_vld && !pick_v;
    gnt_v        = v_vld && pick_v;
    last_grant_d = last_grant_q;
    if (advance) last_grant_d = gnt_v;
  end

  // Priority register
  always_ff @(posedge clk) begin
    if (!rst_l) last_grant_q <= 1'b1;
    else        last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issue front-end for the single-cycle bf16 FPU; optional perf counters under FPU_CTRL_PERF_EN.
// Latency: legal op responds 3 cycles after accept, illegal op 1 cycle; one op in flight.
// Backpressure: req ready only in IDLE; response held stable until rsp_valid & rsp_ready.
module fpu_issue_ctrl #(
  parameter int DATA_W = 16,
  parameter int INT_W  = 32,
  parameter int TAG_W  = 4
`ifdef FPU_CTRL_PERF_EN
  , parameter int PERF_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              s_req_valid,
  output logic              s_req_ready,
  input  logic [4:0]        s_req_op,
  input  logic [1:0]        s_req_sign,
  input  logic [DATA_W-1:0] s_req_a,
  input  logic [DATA_W-1:0] s_req_b,
  input  logic [DATA_W-1:0] s_req_c,
  input  logic [INT_W-1:0]  s_req_int,
  input  logic [2:0]        s_req_frm,
  input  logic [TAG_W-1:0]  s_req_tag,
  input  logic              v_req_valid,
  output logic              v_req_ready,
  input  logic [4:0]        v_req_op,
  input  logic [1:0]        v_req_sign,
  input  logic [DATA_W-1:0] v_req_a,
  input  logic [DATA_W-1:0] v_req_b,
  input  logic [DATA_W-1:0] v_req_c,
  input  logic [INT_W-1:0]  v_req_int,
  input  logic [2:0]        v_req_frm,
  input  logic [TAG_W-1:0]  v_req_tag,
  output logic [DATA_W-1:0] fpu_operand_a,
  output logic [DATA_W-1:0] fpu_operand_b,
  output logic [DATA_W-1:0] fpu_operand_c,
  output logic [INT_W-1:0]  fpu_operand_int,
  output logic [2:0]        fpu_frm,
  output logic [23:0]       fpu_sfpu_op,
  output logic [27:0]       fpu_vfpu_op,
  input  logic [DATA_W-1:0] fpu_resultant,
  input  logic [INT_W-1:0]  fpu_result_rd,
  input  logic [4:0]        fpu_s_flags,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_src,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic [DATA_W-1:0] rsp_fp,
  output logic [INT_W-1:0]  rsp_rd,
  output logic [4:0]        rsp_flags,
  output logic [4:0]        fflags,
  input  logic              fflags_clr
`ifdef FPU_CTRL_PERF_EN
  , output logic [PERF_W-1:0] perf_s_cnt,
  output logic [PERF_W-1:0] perf_v_cnt
`endif
);
  import fpu_ctrl_pkg::*;

  state_e state_q, state_d;
  logic   gnt_s, gnt_v, accept, in_legal, rsp_hs;

  logic [4:0]        op_q, op_d, in_op;
  logic [1:0]        sign_q, sign_d, in_sign;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [INT_W-1:0]  int_q, int_d;
  logic [2:0]        frm_q, frm_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              src_q, src_d;
  logic [DATA_W-1:0] rsp_fp_q, rsp_fp_d;
  logic [INT_W-1:0]  rsp_rd_q, rsp_rd_d;
  logic [4:0]        rsp_flags_q, rsp_flags_d;
  logic [4:0]        fflags_q, fflags_d;

  fpu_rr_arb2 u_arb (
    .clk     (clk),
    .rst_l   (rst_l),
    .s_vld   (s_req_valid),
    .v_vld   (v_req_valid),
    .advance (accept),
    .gnt_s   (gnt_s),
    .gnt_v   (gnt_v)
  );

  assign accept = s_req_ready || v_req_ready;
  assign rsp_hs = rsp_valid && rsp_ready;
  assign in_op   = gnt_v ? v_req_op   : s_req_op;
  assign in_sign = gnt_v ? v_req_sign : s_req_sign;
  assign in_legal = op_is_legal(gnt_v, in_op);

  // Next state: illegal ops skip the FPU and go straight to the response
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept) state_d = in_legal ? ST_ISSUE : ST_RESP;
      ST_ISSUE:   state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_RESP;
      ST_RESP:    if (rsp_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state: ready, one-hot op buses (ISSUE only), rsp_valid
  always_comb begin
    s_req_ready = (state_q == ST_IDLE) && gnt_s;
    v_req_ready = (state_q == ST_IDLE) && gnt_v;
    rsp_valid   = (state_q == ST_RESP);
    fpu_sfpu_op = '0;
    fpu_vfpu_op = '0;
    if (state_q == ST_ISSUE) begin
      if (src_q) begin
        fpu_vfpu_op        = 28'(1) << op_q;
        fpu_vfpu_op[27:26] = fpu_vfpu_op[27:26] | sign_q;
      end else begin
        fpu_sfpu_op        = 24'(1) << op_q;
        fpu_sfpu_op[23:22] = fpu_sfpu_op[23:22] | sign_q;
      end
    end
  end

  // Holding registers load from the granted source on accept
  always_comb begin
    op_d = op_q; sign_d = sign_q; a_d = a_q; b_d = b_q; c_d = c_q;
    int_d = int_q; frm_d = frm_q; tag_d = tag_q; src_d = src_q;
    if (accept) begin
      op_d   = in_op;
      sign_d = in_sign;
      src_d  = gnt_v;
      a_d    = gnt_v ? v_req_a   : s_req_a;
      b_d    = gnt_v ? v_req_b   : s_req_b;
      c_d    = gnt_v ? v_req_c   : s_req_c;
      int_d  = gnt_v ? v_req_int : s_req_int;
      frm_d  = gnt_v ? v_req_frm : s_req_frm;
      tag_d  = gnt_v ? v_req_tag : s_req_tag;
    end
  end

  // Response payload: illegal-op constants at accept, FPU results in CAPTURE
  always_comb begin
    rsp_fp_d    = rsp_fp_q;
    rsp_rd_d    = rsp_rd_q;
    rsp_flags_d = rsp_flags_q;
    if (accept && !in_legal) begin
      rsp_fp_d    = '0;
      rsp_rd_d    = '0;
      rsp_flags_d = FLAGS_ILLEGAL;
    end else if (state_q == ST_CAPTURE) begin
      rsp_fp_d    = fpu_resultant;
      rsp_rd_d    = fpu_result_rd;
      rsp_flags_d = fpu_s_flags;
    end
    // Flags handed over this cycle survive a simultaneous clear
    fflags_d = (fflags_clr ? 5'b0 : fflags_q) | (rsp_hs ? rsp_flags_q : 5'b0);
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state_q <= ST_IDLE;
      op_q <= '0; sign_q <= '0; a_q <= '0; b_q <= '0; c_q <= '0;
      int_q <= '0; frm_q <= '0; tag_q <= '0; src_q <= 1'b0;
      rsp_fp_q <= '0; rsp_rd_q <= '0; rsp_flags_q <= '0; fflags_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d; sign_q <= sign_d; a_q <= a_d; b_q <= b_d; c_q <= c_d;
      int_q <= int_d; frm_q <= frm_d; tag_q <= tag_d; src_q <= src_d;
      rsp_fp_q <= rsp_fp_d; rsp_rd_q <= rsp_rd_d; rsp_flags_q <= rsp_flags_d;
      fflags_q <= fflags_d;
    end
  end

  assign fpu_operand_a   = a_q;
  assign fpu_operand_b   = b_q;
  assign fpu_operand_c   = c_q;
  assign fpu_operand_int = int_q;
  assign fpu_frm         = frm_q;
  assign rsp_src         = src_q;
  assign rsp_tag         = tag_q;
  assign rsp_fp          = rsp_fp_q;
  assign rsp_rd          = rsp_rd_q;
  assign rsp_flags       = rsp_flags_q;
  assign fflags          = fflags_q;

`ifdef FPU_CTRL_PERF_EN
  logic [PERF_W-1:0] perf_s_q, perf_s_d, perf_v_q, perf_v_d;

  // Accepted-request counters per source, illegal ops included
  always_comb begin
    perf_s_d = perf_s_q + PERF_W'(s_req_ready);
    perf_v_d = perf_v_q + PERF_W'(v_req_ready);
  end

  // Perf counter registers
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      perf_s_q <= '0;
      perf_v_q <= '0;
    end else begin
      perf_s_q <= perf_s_d;
      perf_v_q <= perf_v_d;
    end
  end

  assign perf_s_cnt = perf_s_q;
  assign perf_v_cnt = perf_v_q;
`endif

endmodule
